// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: opcode constants
// used by decode/control, the canonical NOP and the fetch FSM encoding.
package fetch_unit_pkg;

  // Major opcodes (instr[6:0]) shared with the control unit
  localparam logic [6:0] OP_ALU_R     = 7'b0110011;
  localparam logic [6:0] OP_ALU_I     = 7'b0010011;
  localparam logic [6:0] OP_BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] OP_JUMP      = 7'b1101111;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, occupancy count and full/empty flags.
// The head entry is presented combinationally from the storage registers.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next storage, pointers and count; a write into a full FIFO is only
  // accepted when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  // Storage and pointer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end. Owns the PC, issues in-order requests under a
// credit limit (outstanding + buffered <= DEPTH), tags each request with its
// PC, and buffers responses for decode. A redirect flushes the buffer and
// discards every response belonging to requests issued before it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [6:0]         if_opcode,
  output logic [PC_W-1:0]    if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [CW-1:0]        drop_q, drop_d;

  logic [CW-1:0]        tag_count_s;
  logic                 tag_full_s;
  logic                 tag_empty_s;
  logic [PC_W-1:0]      tag_head_s;

  logic [CW-1:0]        data_count_s;
  logic                 data_full_s;
  logic                 data_empty_s;
  logic [INSTR_W+PC_W-1:0] data_head_s;

  logic [CW:0]          credit_sum_s;
  logic                 req_valid_s;
  logic                 req_fire_s;
  logic                 rsp_s;
  logic                 push_s;
  logic                 pop_s;
  logic [CW-1:0]        outstanding_next_s;
  logic [PC_W-1:0]      redirect_tgt_s;

  // Tag queue: one entry per request in flight; its occupancy is the
  // outstanding count. Every response pops one tag, stale or not, so the
  // queue stays aligned with the memory's in-order return stream.
  fetch_fifo #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire_s),
    .push_data (pc_q),
    .pop       (rsp_s),
    .head_data (tag_head_s),
    .count     (tag_count_s),
    .full      (tag_full_s),
    .empty     (tag_empty_s)
  );

  // Instruction buffer toward decode: {instruction, pc}
  fetch_fifo #(
    .WIDTH (INSTR_W + PC_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data ({imem_rsp_data, tag_head_s}),
    .pop       (pop_s),
    .head_data (data_head_s),
    .count     (data_count_s),
    .full      (data_full_s),
    .empty     (data_empty_s)
  );

  assign redirect_tgt_s = redirect_pc & ~PC_W'(3);

  // FSM state register plus PC and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: redirect overrides everything; stale requests still in
  // flight after the redirect cycle's accounting become the drop count.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_tgt_s;
      drop_d = outstanding_next_s;
      if (outstanding_next_s == '0) begin
        state_d = ST_FETCH;
      end else begin
        state_d = ST_DRAIN;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (req_fire_s) begin
            pc_d = pc_q + PC_W'(4);
          end else begin
            pc_d = pc_q;
          end
        end
        ST_DRAIN: begin
          if (drop_q == '0) begin
            state_d = ST_FETCH;
          end else if (rsp_s) begin
            drop_d = drop_q - CW'(1);
          end else begin
            drop_d = drop_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Per-cycle controls: request credit check, response routing, decode pop
  always_comb begin
    credit_sum_s = {1'b0, tag_count_s} + {1'b0, data_count_s};
    if ((state_q == ST_FETCH) && (credit_sum_s < (CW+1)'(DEPTH)) &&
        !tag_full_s && !data_full_s) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    req_fire_s = req_valid_s && imem_req_ready;
    rsp_s      = imem_rsp_valid && !tag_empty_s;
    if ((state_q == ST_FETCH) && rsp_s && !redirect_valid) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    pop_s = !data_empty_s && if_ready && !redirect_valid;
    outstanding_next_s = tag_count_s + CW'(req_fire_s) - CW'(rsp_s);
  end

  // Decode-side view of the buffer head; zero whenever nothing is valid
  always_comb begin
    if_valid = !data_empty_s;
    if (!data_empty_s) begin
      if_instr = data_head_s[INSTR_W+PC_W-1:PC_W];
      if_pc    = data_head_s[PC_W-1:0];
    end else begin
      if_instr = '0;
      if_pc    = '0;
    end
    if_opcode = if_instr[6:0];
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W     (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_pc          (if_pc)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  logic [31:0] deliv_pc[$];
  logic [31:0] deliv_instr[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          errors = 0;
  int          checks = 0;

  // Address-derived instruction word with a varying opcode
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    logic [6:0] op;
    case (a[3:2])
      2'd0:    op = OP_ALU_I;
      2'd1:    op = OP_ALU_R;
      2'd2:    op = OP_LOAD;
      default: op = OP_STORE;
    endcase
    return {a[26:2], op};
  endfunction

  // Record request handshakes and decode transfers at the active edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mq.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{cyc + mem_lat, imem_req_addr});
        req_log.push_back(imem_req_addr);
      end
      if (if_valid && if_ready && !redirect_valid) begin
        deliv_pc.push_back(if_pc);
        deliv_instr.push_back(if_instr);
      end
    end
  end

  // Present the oldest response once its latency has elapsed
  always @(negedge clk) begin
    imem_rsp_valid <= 1'b0;
    imem_rsp_data  <= 32'h0;
    if (!rst && mq.size() > 0) begin
      if (mq[0].due <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_data(mq[0].addr);
        void'(mq.pop_front());
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_deliv(input string tag, input int idx, input logic [31:0] exp_pc);
    if (idx < deliv_pc.size()) begin
      chk({tag, "_pc"}, deliv_pc[idx], exp_pc);
      chk({tag, "_instr"}, deliv_instr[idx], mem_data(exp_pc));
    end else begin
      chk({tag, "_missing"}, 32'(deliv_pc.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_req(input string tag, input int idx, input logic [31:0] exp_addr);
    if (idx < req_log.size()) begin
      chk(tag, req_log[idx], exp_addr);
    end else begin
      chk({tag, "_missing"}, 32'(req_log.size()), 32'(idx + 1));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_on();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick(2);
    req_log.delete();
    deliv_pc.delete();
    deliv_instr.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int stale;
    logic [31:0] exp_addr;

    rst = 1'b1;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // 1: reset values, first fetch latency, sequential stream, credit limit
    mem_lat = 1;
    reset_on();
    chk_reset_outputs("s1_rst");
    rst = 1'b0;
    tick(1);
    chk("s1_req_valid_e1", 32'(imem_req_valid), 32'd1);
    chk("s1_req_addr_e1", imem_req_addr, 32'h0);
    chk("s1_if_valid_e1", 32'(if_valid), 32'd0);
    tick(1);
    chk("s1_if_valid_e2", 32'(if_valid), 32'd0);
    tick(1);
    chk("s1_if_valid_e3", 32'(if_valid), 32'd1);
    chk("s1_if_pc_e3", if_pc, 32'h0);
    chk("s1_if_instr_e3", if_instr, mem_data(32'h0));
    chk("s1_if_opcode_e3", 32'(if_opcode), 32'(OP_ALU_I));
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("s1_credit", 32'((req_log.size() - deliv_pc.size()) <= 2), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      chk_req("s1_req", i, 32'(4 * i));
      chk_deliv("s1_deliv", i, 32'(4 * i));
    end

    // 2: decode stalled -> two buffered, requests stop, head stable
    if_ready = 1'b0;
    reset_on();
    rst = 1'b0;
    tick(4);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("s2_if_valid", 32'(if_valid), 32'd1);
      chk("s2_if_pc", if_pc, 32'h0);
      chk("s2_if_instr", if_instr, mem_data(32'h0));
      chk("s2_req_valid", 32'(imem_req_valid), 32'd0);
    end
    chk("s2_req_count", 32'(req_log.size()), 32'd2);
    if_ready = 1'b1;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      chk_deliv("s2_deliv", i, 32'(4 * i));
    end

    // 3: redirect with two requests in flight (latency 3)
    mem_lat = 3;
    reset_on();
    rst = 1'b0;
    tick(3);
    chk("s3_req_valid_pre", 32'(imem_req_valid), 32'd0);
    chk("s3_req_count_pre", 32'(req_log.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick(1);
    redirect_valid = 1'b0;
    chk("s3_req_valid_drain", 32'(imem_req_valid), 32'd0);
    chk("s3_if_valid_drain", 32'(if_valid), 32'd0);
    tick(20);
    chk_req("s3_req_after", 2, 32'h0000_0100);
    chk_deliv("s3_deliv0", 0, 32'h0000_0100);
    stale = 0;
    foreach (deliv_pc[i]) if (deliv_pc[i] < 32'h0000_0100) stale++;
    chk("s3_stale", 32'(stale), 32'd0);

    // 4a: redirect coinciding with a request handshake and a response
    mem_lat = 1;
    reset_on();
    rst = 1'b0;
    tick(2);
    chk("s4a_req_valid_pre", 32'(imem_req_valid), 32'd1);
    chk("s4a_req_addr_pre", imem_req_addr, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick(1);
    redirect_valid = 1'b0;
    chk("s4a_if_valid", 32'(if_valid), 32'd0);
    chk("s4a_req_valid_drain", 32'(imem_req_valid), 32'd0);
    tick(12);
    chk_req("s4a_req0", 0, 32'h0);
    chk_req("s4a_req1", 1, 32'h4);
    chk_req("s4a_req2", 2, 32'h0000_0300);
    chk_deliv("s4a_deliv0", 0, 32'h0000_0300);
    stale = 0;
    foreach (deliv_pc[i]) if (deliv_pc[i] < 32'h0000_0300) stale++;
    chk("s4a_stale", 32'(stale), 32'd0);

    // 4b: redirect coinciding with a response and a decode pop; unaligned target
    reset_on();
    rst = 1'b0;
    tick(3);
    chk("s4b_if_valid_pre", 32'(if_valid), 32'd1);
    chk("s4b_if_pc_pre", if_pc, 32'h0);
    chk("s4b_req_valid_pre", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0403;
    tick(1);
    redirect_valid = 1'b0;
    chk("s4b_if_valid", 32'(if_valid), 32'd0);
    chk("s4b_req_valid", 32'(imem_req_valid), 32'd1);
    chk("s4b_req_addr", imem_req_addr, 32'h0000_0400);
    tick(10);
    chk_deliv("s4b_deliv0", 0, 32'h0000_0400);
    stale = 0;
    foreach (deliv_pc[i]) if (deliv_pc[i] < 32'h0000_0400) stale++;
    chk("s4b_stale", 32'(stale), 32'd0);

    // 5: second redirect while draining
    mem_lat = 3;
    reset_on();
    rst = 1'b0;
    tick(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick(1);
    redirect_pc = 32'h0000_0200;
    tick(1);
    redirect_valid = 1'b0;
    chk("s5_req_valid_drain", 32'(imem_req_valid), 32'd0);
    tick(20);
    chk_req("s5_req_after", 2, 32'h0000_0200);
    chk_deliv("s5_deliv0", 0, 32'h0000_0200);
    stale = 0;
    foreach (deliv_pc[i]) if (deliv_pc[i] < 32'h0000_0200) stale++;
    foreach (req_log[i]) if (req_log[i] >= 32'h0000_0100 && req_log[i] < 32'h0000_0200) stale++;
    chk("s5_old_path", 32'(stale), 32'd0);

    // 6: memory stall holds the address, then reset mid-stream
    mem_lat = 1;
    reset_on();
    rst = 1'b0;
    tick(8);
    imem_req_ready = 1'b0;
    exp_addr = 32'h0;
    if (req_log.size() > 0) exp_addr = req_log[$] + 32'd4;
    chk("s6_req_seen", 32'(req_log.size() > 0), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      if (i >= 3) begin
        chk("s6_stall_valid", 32'(imem_req_valid), 32'd1);
        chk("s6_stall_addr", imem_req_addr, exp_addr);
      end
    end
    reset_on();
    chk_reset_outputs("s6_rst");
    imem_req_ready = 1'b1;
    rst = 1'b0;
    tick(6);
    chk_req("s6_restart_req", 0, 32'h0);
    chk_deliv("s6_restart_deliv", 0, 32'h0);

    // 7: PC increment wraps around the address space
    reset_on();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    rst = 1'b0;
    tick(1);
    redirect_valid = 1'b0;
    chk("s7_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    chk("s7_req_valid_top", 32'(imem_req_valid), 32'd1);
    tick(1);
    chk("s7_req_addr_wrap", imem_req_addr, 32'h0);
    tick(10);
    chk_req("s7_req0", 0, 32'hFFFF_FFFC);
    chk_req("s7_req1", 1, 32'h0);
    chk_deliv("s7_deliv0", 0, 32'hFFFF_FFFC);
    chk_deliv("s7_deliv1", 1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
